// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus between the instruction-fetch (IF)
// master and the data-memory (MEM) master of the five-stage pipeline. Only
// one transfer is ever outstanding. MEM wins a simultaneous request because
// it belongs to the older instruction. Returned read data is held in a
// per-master register until the owning pipeline stage advances.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous reset, ACTIVE HIGH despite the name
//   stall[5:0]   : pipeline stall vector, [1] = IF stage, [4] = MEM stage
//   flush        : pipeline flush, discards the transfer in flight
//   if_req       : IF read request, held with if_addr until stallreq_if = 0
//   if_addr      : fetch address
//   if_rdata     : registered fetch data
//   stallreq_if  : IF stall request (combinational)
//   mem_req      : MEM access request, held with qualifiers until granted
//   mem_we       : 1 = write
//   mem_sel      : byte enables
//   mem_addr     : data address
//   mem_wdata    : write data
//   mem_rdata    : registered load data
//   stallreq_mem : MEM stall request (combinational)
//   bus_stb/we/sel/addr/wdata : registered bus cycle outputs
//   bus_rdata    : slave read data, valid with bus_ack
//   bus_ack      : slave completion, one cycle per transfer
// ---------------------------------------------------------------------------
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        stallreq_if,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq_mem,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUS_MEM = 3'd1,
    BUS_IF  = 3'd2,
    RET_MEM = 3'd3,
    RET_IF  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_discard;
  logic   w_discard;
  logic   w_in_bus;
  logic   w_unused_stall;

  // Only the IF and MEM stage stall bits matter to this block.
  assign w_unused_stall = ^{stall[5], stall[3:2], stall[0]};

  // A flush in the ack cycle itself must also kill the transfer, so the
  // live flush is folded in alongside the sticky flag.
  assign w_discard = r_discard | flush;
  assign w_in_bus  = (r_state == BUS_MEM) || (r_state == BUS_IF);

  // State register and the sticky discard flag. The flag remembers a flush
  // seen in any cycle of the bus phase and is cleared whenever the bus phase
  // ends, so it never leaks into the next transfer.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_in_bus && !bus_ack) begin
        r_discard <= w_discard;
      end else begin
        r_discard <= 1'b0;
      end
    end
  end

  // Next-state and stall-request decode. Outside its own bus/return phases a
  // master is stalled exactly while it is requesting, which also keeps the
  // losing master stalled while the other one owns the bus.
  always_comb begin
    w_next_state = r_state;
    stallreq_if  = if_req;
    stallreq_mem = mem_req;
    case (r_state)
      IDLE: begin
        if (!flush) begin
          if (mem_req) begin
            w_next_state = BUS_MEM;
          end else if (if_req) begin
            w_next_state = BUS_IF;
          end
        end
      end
      BUS_MEM: begin
        stallreq_mem = 1'b1;
        if (bus_ack) begin
          w_next_state = w_discard ? IDLE : RET_MEM;
        end
      end
      BUS_IF: begin
        stallreq_if = 1'b1;
        if (bus_ack) begin
          w_next_state = w_discard ? IDLE : RET_IF;
        end
      end
      RET_MEM: begin
        stallreq_mem = 1'b0;
        if (!stall[4] || flush) begin
          w_next_state = IDLE;
        end
      end
      RET_IF: begin
        stallreq_if = 1'b0;
        if (!stall[1] || flush) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Bus control and read-data registers. The bus registers are loaded only
  // on the grant out of IDLE and touched again only on the ack, so they stay
  // frozen for the whole wait period. Address, select and write data are
  // left as they were after the ack; only strobe and write enable drop.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_next_state == BUS_MEM) begin
            bus_stb   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (w_next_state == BUS_IF) begin
            bus_stb   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'hF;
            bus_addr  <= if_addr;
            bus_wdata <= 32'h0;
          end
        end
        BUS_MEM, BUS_IF: begin
          if (bus_ack) begin
            bus_stb <= 1'b0;
            bus_we  <= 1'b0;
            // Writes and discarded transfers leave the return data alone.
            if (!w_discard && !bus_we) begin
              if (r_state == BUS_MEM) begin
                mem_rdata <= bus_rdata;
              end else begin
                if_rdata <= bus_rdata;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter. Each request driven through
// applyStimulus pushes the bus transfer it should produce onto a queue; the
// slave model in serveBus pops that entry when the strobe appears and checks
// the bus against it, then acks after a chosen number of wait states.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        stallreq_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  typedef struct {
    logic        isMem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busTxn_t;

  busTxn_t     sbBus[$];
  logic [31:0] modelIfRdata;
  logic [31:0] modelMemRdata;
  int          nCompared;
  int          nMismatched;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .stallreq_if  (stallreq_if),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .bus_stb      (bus_stb),
    .bus_we       (bus_we),
    .bus_sel      (bus_sel),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // The single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request from one master and queue the bus transfer it implies.
  // An instruction fetch always appears on the bus as a full-word read.
  task automatic applyStimulus(input logic isMem, input logic we,
                               input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata);
    busTxn_t t;
    t.isMem = isMem;
    t.addr  = addr;
    if (isMem) begin
      mem_req   = 1'b1;
      mem_we    = we;
      mem_sel   = sel;
      mem_addr  = addr;
      mem_wdata = wdata;
      t.we      = we;
      t.sel     = sel;
      t.wdata   = wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
      t.we    = 1'b0;
      t.sel   = 4'hF;
      t.wdata = 32'h0;
    end
    sbBus.push_back(t);
  endtask

  // Slave model. Called from an IDLE cycle holding a request: expects the
  // strobe after the next edge, checks the bus against the scoreboard on
  // every bus cycle, acks after 'waits' wait states and optionally pulses
  // flush in bus cycle 'flushCycle'. Returns 1 ns after the ack edge.
  task automatic serveBus(input int waits, input logic [31:0] ackData,
                          input int flushCycle);
    busTxn_t exp;
    int      n;
    bit      discard;
    n       = 0;
    discard = 0;
    step();
    while (bus_stb !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("grantLatency", n, 0);
    if (bus_stb !== 1'b1) begin
      return;
    end
    if (sbBus.size() == 0) begin
      checkOutput("scoreboardDepth", sbBus.size(), 1);
      return;
    end
    exp = sbBus.pop_front();
    for (int j = 0; j <= waits; j++) begin
      if (j > 0) begin
        step();
      end
      checkOutput("busStb",   bus_stb,   1'b1);
      checkOutput("busWe",    bus_we,    exp.we);
      checkOutput("busSel",   bus_sel,   exp.sel);
      checkOutput("busAddr",  bus_addr,  exp.addr);
      checkOutput("busWdata", bus_wdata, exp.wdata);
      if (exp.isMem) begin
        checkOutput("stallreqMemInBus", stallreq_mem, 1'b1);
        checkOutput("stallreqIfWaiting", stallreq_if, if_req);
      end else begin
        checkOutput("stallreqIfInBus", stallreq_if, 1'b1);
        checkOutput("stallreqMemWaiting", stallreq_mem, mem_req);
      end
      flush = (j == flushCycle);
      if (j == flushCycle) begin
        discard = 1;
      end
      bus_ack   = (j == waits);
      bus_rdata = (j == waits) ? ackData : $urandom();
    end
    step();
    bus_ack   = 1'b0;
    flush     = 1'b0;
    bus_rdata = 32'h0;
    checkOutput("stbDropAfterAck", bus_stb, 1'b0);
    checkOutput("weDropAfterAck",  bus_we,  1'b0);
    if (!exp.we && !discard) begin
      if (exp.isMem) begin
        modelMemRdata = ackData;
      end else begin
        modelIfRdata = ackData;
      end
    end
  endtask

  initial begin
    nCompared     = 0;
    nMismatched   = 0;
    modelIfRdata  = 32'h0;
    modelMemRdata = 32'h0;
    rst_n     = 1'b1;
    stall     = 6'b0;
    flush     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    bus_rdata = 32'h0;
    bus_ack   = 1'b0;

    // Reset state, plus the stall request passing straight through in reset.
    repeat (2) step();
    if_req = 1'b1;
    #1;
    checkOutput("rstStallreqIf", stallreq_if, 1'b1);
    if_req = 1'b0;
    #1;
    checkOutput("rstStallreqIfLow", stallreq_if, 1'b0);
    rst_n = 1'b0;
    step();
    checkOutput("rstBusStb",   bus_stb,   1'b0);
    checkOutput("rstBusWe",    bus_we,    1'b0);
    checkOutput("rstBusSel",   bus_sel,   4'h0);
    checkOutput("rstBusAddr",  bus_addr,  32'h0);
    checkOutput("rstBusWdata", bus_wdata, 32'h0);
    checkOutput("rstIfRdata",  if_rdata,  32'h0);
    checkOutput("rstMemRdata", mem_rdata, 32'h0);

    // Single zero-wait fetch: stall request high in the request and bus
    // cycles only, data valid in the return cycle.
    $display("[TB] single fetch, zero-wait");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0);
    #1;
    checkOutput("fetchStallreqCycle0", stallreq_if, 1'b1);
    serveBus(0, 32'h2401_0005, -1);
    checkOutput("fetchStallreqRet", stallreq_if, 1'b0);
    checkOutput("fetchIfRdata", if_rdata, modelIfRdata);
    if_req = 1'b0;
    step();

    // Contention: MEM load goes first, IF waits stalled until after RET_MEM.
    $display("[TB] contention, 2 wait states");
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0);
    #1;
    checkOutput("contStallreqMem0", stallreq_mem, 1'b1);
    checkOutput("contStallreqIf0",  stallreq_if,  1'b1);
    serveBus(2, 32'h0BAD_F00D, -1);
    checkOutput("contMemRdata",     mem_rdata,    modelMemRdata);
    checkOutput("contStallreqMemR", stallreq_mem, 1'b0);
    checkOutput("contStallreqIfR",  stallreq_if,  1'b1);
    mem_req = 1'b0;
    step();
    checkOutput("contNoStbInIdle", bus_stb,     1'b0);
    checkOutput("contStallreqIfI", stallreq_if, 1'b1);
    serveBus(0, 32'h1111_2222, -1);
    checkOutput("contIfRdata", if_rdata, modelIfRdata);
    if_req = 1'b0;
    step();

    // Store: bus held through a wait state, load data left alone.
    $display("[TB] store");
    applyStimulus(1'b1, 1'b1, 4'b0011, 32'h0000_3000, 32'hDEAD_BEEF);
    serveBus(1, 32'hFFFF_FFFF, -1);
    checkOutput("storeMemRdata", mem_rdata, 32'h0BAD_F00D);
    checkOutput("storeBusWe",    bus_we,    1'b0);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    step();

    // Return hold: MEM stage stalled for 3 cycles after the ack. The request
    // stays up, so leaving RET_MEM early would show as a stall request.
    $display("[TB] return hold");
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_2004, 32'h0);
    serveBus(0, 32'hCAFE_0001, -1);
    stall = 6'b01_0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput("holdStallreqMem", stallreq_mem, 1'b0);
      checkOutput("holdMemRdata",    mem_rdata,    32'hCAFE_0001);
      checkOutput("holdBusStb",      bus_stb,      1'b0);
      step();
    end
    stall = 6'b0;
    #1;
    checkOutput("holdReleaseStallreq", stallreq_mem, 1'b0);
    step();
    checkOutput("holdBackInIdle", stallreq_mem, 1'b1);
    sbBus.delete();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0);
    serveBus(0, 32'h0000_0005, -1);
    checkOutput("holdNextLoad", mem_rdata, 32'h0000_0005);
    mem_req = 1'b0;
    step();

    // Flush in flight: pulse in the first bus cycle, ack two cycles later.
    $display("[TB] flush in flight");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
    serveBus(2, 32'h1234_5678, 0);
    checkOutput("flushIfRdata",   if_rdata,    32'h1111_2222);
    checkOutput("flushToIdle",    stallreq_if, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0204, 32'h0);
    serveBus(0, 32'h0000_AAAA, -1);
    checkOutput("flushRefetch", if_rdata, 32'h0000_AAAA);
    if_req = 1'b0;
    step();

    // Flush landing on the ack cycle itself.
    $display("[TB] flush coincident with ack");
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_5000, 32'h0);
    serveBus(0, 32'h7777_7777, 0);
    checkOutput("flushAckMemRdata", mem_rdata,    32'h0000_0005);
    checkOutput("flushAckToIdle",   stallreq_mem, 1'b1);
    mem_req = 1'b0;
    step();

    // Async reset in the middle of a MEM bus cycle; late ack is ignored.
    $display("[TB] async reset mid-transfer");
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_sel  = 4'hF;
    mem_addr = 32'h0000_4000;
    step();
    checkOutput("rstMidStbBefore", bus_stb, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rstMidStbDrop",   bus_stb,      1'b0);
    checkOutput("rstMidAddr",      bus_addr,     32'h0);
    checkOutput("rstMidStallreq",  stallreq_mem, 1'b1);
    mem_req = 1'b0;
    step();
    rst_n         = 1'b0;
    modelIfRdata  = 32'h0;
    modelMemRdata = 32'h0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h9999_9999;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    checkOutput("lateAckStb",      bus_stb,      1'b0);
    checkOutput("lateAckWe",       bus_we,       1'b0);
    checkOutput("lateAckSel",      bus_sel,      4'h0);
    checkOutput("lateAckAddr",     bus_addr,     32'h0);
    checkOutput("lateAckWdata",    bus_wdata,    32'h0);
    checkOutput("lateAckIfRdata",  if_rdata,     modelIfRdata);
    checkOutput("lateAckMemRdata", mem_rdata,    modelMemRdata);
    checkOutput("lateAckStallIf",  stallreq_if,  1'b0);
    checkOutput("lateAckStallMem", stallreq_mem, 1'b0);
    mem_req = 1'b1;
    #1;
    checkOutput("lateAckIdle", stallreq_mem, 1'b1);
    mem_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
